display_scan_scheduler: RTL and testbench

Time-slot scheduler that shares one seven-segment decoder between the two digits of the dual display. It alternates ownership between digit 1 and digit 2. Each slot opens with a blanking window, with both anodes off, to suppress ghosting while the decoder input changes. The selected digit's 4-bit value is frozen for the whole show window, and per-digit enables are supported. The block sits between the digit-value sources (switch inputs / sum logic) and the shared sevenSegmentDisplay decoder plus anode drivers.

---
 rtl/display_scan_scheduler.sv | 124 ++++++++++++
 tb/tb_display_scan_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// Two-digit time-slot scan scheduler with per-slot blanking and value freeze.
// Optional PWM dimming of the lit digit when DISPLAY_DIM_EN is defined.
module display_scan_scheduler #(
  parameter int SLOT_CYCLES  = 48000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic       en1,
  input  logic       en2,
`ifdef DISPLAY_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [3:0] seg_val,
  output logic       sel,
  output logic       an1,
  output logic       an2,
  output logic       slot_tick
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK1,
    SHOW1,
    BLANK2,
    SHOW2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    seg_q, seg_d;
  logic          sel_q, sel_d;
  logic          an1_q, an1_d;
  logic          an2_q, an2_d;
  logic          tick_q, tick_d;
  logic          lit;

`ifdef DISPLAY_DIM_EN
  logic [3:0]    pwm_q, pwm_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == SLOT_LAST) ? '0 : cnt_q + CW'(1);
    seg_d   = seg_q;
    sel_d   = (state_q == BLANK2) || (state_q == SHOW2);
    tick_d  = (cnt_q == '0);
    an1_d   = 1'b1;
    an2_d   = 1'b1;
`ifdef DISPLAY_DIM_EN
    lit     = (pwm_q <= brightness);
`else
    lit     = 1'b1;
`endif
    unique case (state_q)
      BLANK1: begin
        seg_d = s1;
        if (cnt_q == BLANK_LAST) state_d = SHOW1;
      end
      SHOW1: begin
        an1_d = ~(en1 & lit);
        if (cnt_q == SLOT_LAST) state_d = BLANK2;
      end
      BLANK2: begin
        seg_d = s2;
        if (cnt_q == BLANK_LAST) state_d = SHOW2;
      end
      SHOW2: begin
        an2_d = ~(en2 & lit);
        if (cnt_q == SLOT_LAST) state_d = BLANK1;
      end
      default: state_d = BLANK1;
    endcase
  end

`ifdef DISPLAY_DIM_EN
  // PWM phase restarts at the first show cycle of every slot
  always_comb begin
    pwm_d = pwm_q;
    if ((state_q == BLANK1) || (state_q == BLANK2)) begin
      if ((state_d == SHOW1) || (state_d == SHOW2)) pwm_d = '0;
    end else begin
      pwm_d = pwm_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      seg_q   <= '0;
      sel_q   <= 1'b0;
      an1_q   <= 1'b1;
      an2_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      an1_q   <= an1_d;
      an2_q   <= an2_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_val   = seg_q;
  assign sel       = sel_q;
  assign an1       = an1_q;
  assign an2       = an2_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomized bench for display_scan_scheduler against a slot-position model.
// Define DISPLAY_DIM_EN for both files to exercise the dimming build.
module tb_display_scan_scheduler;

`ifdef DISPLAY_DIM_EN
  localparam int S = 40;
  localparam int B = 4;
`else
  localparam int S = 8;
  localparam int B = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s1, s2;
  logic       en1, en2;
  logic [3:0] bright;
  logic [3:0] seg_val;
  logic       sel, an1, an2, slot_tick;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  bit chk_en = 1'b0;

  int e_seg, e_sel, e_an1, e_an2, e_tick;
  int m_frz = 0;

  display_scan_scheduler #(
    .SLOT_CYCLES (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s1       (s1),
    .s2       (s2),
    .en1      (en1),
    .en2      (en2),
`ifdef DISPLAY_DIM_EN
    .brightness(bright),
`endif
    .seg_val  (seg_val),
    .sel      (sel),
    .an1      (an1),
    .an2      (an2),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  // Expected outputs after edge kn, from the slot position in the frame
  task automatic model(input int kn);
    int p, slot, off, dimok;
    p     = (kn - 1) % (2 * S);
    slot  = p / S;
    off   = p % S;
    dimok = 1;
`ifdef DISPLAY_DIM_EN
    if (off >= B) dimok = (((off - B) % 16) <= int'(bright)) ? 1 : 0;
`endif
    if (off < B) m_frz = (slot == 0) ? int'(s1) : int'(s2);
    e_seg  = m_frz;
    e_sel  = slot;
    e_tick = (off == 0) ? 1 : 0;
    e_an1  = (slot == 0 && off >= B && en1 && dimok != 0) ? 0 : 1;
    e_an2  = (slot == 1 && off >= B && en2 && dimok != 0) ? 0 : 1;
  endtask

  task automatic step();
    model(k + 1);
    chk_en = 1'b1;
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("seg_val", int'(seg_val), e_seg);
      chk("sel", int'(sel), e_sel);
      chk("an1", int'(an1), e_an1);
      chk("an2", int'(an2), e_an2);
      chk("slot_tick", int'(slot_tick), e_tick);
      chk("an_excl", int'(an1 | an2), 1);
    end
  end

  initial begin
    int c1, c2, ct;
    reset  = 1'b0;
    bright = 4'd15;
    s1 = 4'($urandom); s2 = 4'($urandom);
    en1 = 1'($urandom); en2 = 1'($urandom);
    repeat (4) begin
      @(negedge clk);
      s1 = 4'($urandom); s2 = 4'($urandom);
      en1 = 1'($urandom); en2 = 1'($urandom);
    end
    chk("rst_an1", int'(an1), 1);
    chk("rst_an2", int'(an2), 1);
    chk("rst_sel", int'(sel), 0);
    chk("rst_seg", int'(seg_val), 0);
    chk("rst_tick", int'(slot_tick), 0);

    s1 = 4'h3; s2 = 4'hA; en1 = 1'b1; en2 = 1'b1;
    reset = 1'b1;
    k = 0;
    step();
    chk("lit_seg_e1", int'(seg_val), 3);
    chk("lit_tick_e1", int'(slot_tick), 1);

    s1 = 4'h5;
    for (int e = 2; e <= 2 * S + 1; e++) begin
      if (e == B + 3) s1 = 4'h9;
      step();
      if (k == B) chk("lit_an1_blank", int'(an1), 1);
      if (k == B + 1) chk("lit_an1_on", int'(an1), 0);
      if (k == S) begin
        chk("lit_an1_last", int'(an1), 0);
        chk("lit_freeze", int'(seg_val), 5);
      end
      if (k == S + 1) chk("lit_an1_off", int'(an1), 1);
      if (k == S + B + 1) chk("lit_an2_on", int'(an2), 0);
      if (k == 2 * S) chk("lit_an2_last", int'(an2), 0);
      if (k == 2 * S + 1) begin
        chk("lit_an2_off", int'(an2), 1);
        chk("lit_seg_new", int'(seg_val), 9);
      end
    end

    en1 = 1'b0;
    c1 = 0; c2 = 0; ct = 0;
    repeat (2 * S) begin
      step();
      if (!an1) c1++;
      if (!an2) c2++;
      if (slot_tick) ct++;
    end
    chk("lit_dis_an1", c1, 0);
    chk("lit_dis_an2", c2, S - B);
    chk("lit_dis_tick", ct, 2);

    repeat (10 * 2 * S) begin
      s1 = 4'($urandom); s2 = 4'($urandom);
      if ($urandom_range(7) == 0) en1 = ~en1;
      if ($urandom_range(7) == 0) en2 = ~en2;
`ifdef DISPLAY_DIM_EN
      if ($urandom_range(15) == 0) bright = 4'($urandom);
`endif
      step();
    end

`ifdef DISPLAY_DIM_EN
    bright = 4'd3; en1 = 1'b1; en2 = 1'b1;
    while (((k - 1) % (2 * S)) != 2 * S - 1) step();
    c1 = 0;
    repeat (S) begin
      step();
      if (!an1) c1++;
    end
    chk("lit_dim_an1", c1, 12);
    bright = 4'd15;
`endif

    en2 = 1'b1;
    do step(); while (((k - 1) % (2 * S)) != S + B + 1);
    chk("lit_pre_an2", int'(an2), 0);
    chk_en = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("lit_arst_an2", int'(an2), 1);
    chk("lit_arst_sel", int'(sel), 0);
    chk("lit_arst_tick", int'(slot_tick), 0);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    en1 = 1'b1;
    repeat (B + 1) begin
      step();
      if (k == B) chk("lit_re_an1_off", int'(an1), 1);
      if (k == B + 1) chk("lit_re_an1_on", int'(an1), 0);
    end

    repeat (4 * 2 * S) begin
      s1 = 4'($urandom); s2 = 4'($urandom);
      if ($urandom_range(5) == 0) en1 = ~en1;
      if ($urandom_range(5) == 0) en2 = ~en2;
      step();
    end
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
